// File: rtl/ddr4_lane_read_eye_centering_ctrl_if.sv
// Lane-side bundle between the read eye-centering controller and the lane IOD / training top.
// master = controller, slave = IOD wrapper plus training top level.
interface ddr4_lane_read_eye_centering_ctrl_if #(
    parameter int TAP_W = 8
);
    logic             START;
    logic             EYE_MONITOR_EARLY_0;
    logic             EYE_MONITOR_LATE_0;
    logic             DELAY_LINE_OUT_OF_RANGE_0;
    logic             DELAY_LINE_LOAD_0;
    logic             DELAY_LINE_MOVE_0;
    logic             DELAY_LINE_DIRECTION_0;
    logic             EYE_MONITOR_CLEAR_FLAGS_0;
    logic             BUSY;
    logic             DONE;
    logic             FAIL;
    logic [TAP_W-1:0] CENTER_TAP;
    logic [TAP_W-1:0] WINDOW_FIRST;
    logic [TAP_W-1:0] WINDOW_LAST;

    modport master (
        input  START, EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0, DELAY_LINE_OUT_OF_RANGE_0,
        output DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
               EYE_MONITOR_CLEAR_FLAGS_0, BUSY, DONE, FAIL, CENTER_TAP, WINDOW_FIRST, WINDOW_LAST
    );

    modport slave (
        output START, EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0, DELAY_LINE_OUT_OF_RANGE_0,
        input  DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
               EYE_MONITOR_CLEAR_FLAGS_0, BUSY, DONE, FAIL, CENTER_TAP, WINDOW_FIRST, WINDOW_LAST
    );
endinterface

// File: rtl/ddr4_lane_read_eye_centering_ctrl.sv
// Per-lane read eye-centering sequencer: sweeps RX taps up from load, finds the first clean
// window, then reloads the delay line and steps it to the window centre.
module ddr4_lane_read_eye_centering_ctrl #(
    parameter int TAP_W         = 8,
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int MIN_WINDOW    = 4
) (
    input logic FAB_CLK,
    input logic RESET_N,
    ddr4_lane_read_eye_centering_ctrl_if.master lane
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP,
        S_CALC, S_RELOAD, S_MOVE_C, S_GAP, S_DONE, S_FAIL
    } state_t;

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_LIMIT   = TAP_W'(MAX_TAPS - 1);
    localparam logic [TAP_W:0]   MIN_WIN     = (TAP_W + 1)'(MIN_WINDOW);

    state_t           state_q, state_d;
    logic [TAP_W-1:0] tap_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dirty_q;
    logic             in_win_q;
    logic [TAP_W-1:0] first_q, last_q, center_q;

    logic             load, move, clear;
    logic             idle_like;
    logic [TAP_W:0]   win_len;
    logic [TAP_W:0]   win_sum;
    logic             win_ok;

    // Sum and width carry one extra bit so a window ending at the top tap cannot wrap.
    assign win_len   = {1'b0, last_q} - {1'b0, first_q} + 1'b1;
    assign win_sum   = {1'b0, first_q} + {1'b0, last_q};
    assign win_ok    = in_win_q && (win_len >= MIN_WIN);
    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        move    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: if (lane.START) state_d = S_LOAD;
            S_LOAD: begin
                load    = 1'b1;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                clear   = 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
            S_SAMPLE: if (cnt_q == SAMPLE_LAST) state_d = S_EVAL;
            S_EVAL: begin
                // A dirty tap after a clean run closes the window before any range check.
                if (dirty_q && in_win_q)
                    state_d = S_CALC;
                else if (lane.DELAY_LINE_OUT_OF_RANGE_0 || (tap_q == TAP_LIMIT))
                    state_d = S_CALC;
                else
                    state_d = S_STEP;
            end
            S_STEP: begin
                move    = 1'b1;
                state_d = S_CLEAR;
            end
            S_CALC:   state_d = win_ok ? S_RELOAD : S_FAIL;
            S_RELOAD: begin
                load    = 1'b1;
                state_d = S_MOVE_C;
            end
            S_MOVE_C: begin
                if (tap_q == center_q) begin
                    state_d = S_DONE;
                end else begin
                    move    = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP:   state_d = S_MOVE_C;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            tap_q    <= '0;
            cnt_q    <= '0;
            dirty_q  <= 1'b0;
            in_win_q <= 1'b0;
            first_q  <= '0;
            last_q   <= '0;
            center_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (lane.START) begin
                        first_q  <= '0;
                        last_q   <= '0;
                        center_q <= '0;
                        in_win_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    tap_q    <= '0;
                    in_win_q <= 1'b0;
                end
                S_CLEAR: begin
                    dirty_q <= 1'b0;
                    cnt_q   <= '0;
                end
                S_SETTLE: cnt_q <= (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
                S_SAMPLE: begin
                    dirty_q <= dirty_q | lane.EYE_MONITOR_EARLY_0 | lane.EYE_MONITOR_LATE_0;
                    cnt_q   <= cnt_q + 1'b1;
                end
                S_EVAL: begin
                    if (!dirty_q) begin
                        last_q <= tap_q;
                        if (!in_win_q) begin
                            first_q  <= tap_q;
                            in_win_q <= 1'b1;
                        end
                    end
                end
                S_STEP: tap_q <= tap_q + 1'b1;
                S_CALC: if (win_ok) center_q <= TAP_W'(win_sum >> 1);
                S_RELOAD: tap_q <= '0;
                S_MOVE_C: if (tap_q != center_q) tap_q <= tap_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign lane.DELAY_LINE_LOAD_0         = load;
    assign lane.DELAY_LINE_MOVE_0         = move;
    assign lane.DELAY_LINE_DIRECTION_0    = move;
    assign lane.EYE_MONITOR_CLEAR_FLAGS_0 = clear;
    assign lane.BUSY                      = !idle_like;
    assign lane.DONE                      = (state_q == S_DONE);
    assign lane.FAIL                      = (state_q == S_FAIL);
    assign lane.CENTER_TAP                = center_q;
    assign lane.WINDOW_FIRST              = first_q;
    assign lane.WINDOW_LAST               = last_q;

endmodule
